phase_seq: RTL

Parametrised multi-phase clock-enable sequencer for the cpu15 core; successor to the fixed four-phase generator. It produces a one-hot phase vector, one phase per pipeline step (fetch/decode/execute/writeback when NUM_PHASES=4). Unlike the fixed generator, it adds run/idle control, single-instruction stepping, per-phase wait-state stretching, a stall hold and a completed-cycle counter. Phase outputs feed the datapath as enables in the CLK domain.

---
 rtl/phase_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/phase_seq.sv
// Multi-phase clock-enable sequencer: one-hot phase enables per instruction
// cycle, with run/step control, per-phase wait stretching, stall and a cycle count.
module phase_seq #(
  parameter int NUM_PHASES = 4,
  parameter int WAIT_W     = 4,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  RUN,
  input  logic                  STEP,
  input  logic                  STALL,
  input  logic [WAIT_W-1:0]     PHASE_WAIT,
  output logic [NUM_PHASES-1:0] PHASE,
  output logic [IDX_W-1:0]      PHASE_IDX,
  output logic                  CYCLE_END,
  output logic                  BUSY,
  output logic [CNT_W-1:0]      CYCLE_CNT
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] FIRST_PHASE = NUM_PHASES'(1);

  state_t                  state_q, state_d;
  logic [NUM_PHASES-1:0]   phase_q, phase_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    step_q, step_d;
  logic                    cycle_end;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    cycle_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RUN || STEP) begin
          state_d = S_ACTIVE;
          phase_d = FIRST_PHASE;
          idx_d   = '0;
          wait_d  = PHASE_WAIT;
          // A STEP only counts as a single-step when RUN is not also asking to run.
          step_d  = !RUN;
        end
      end
      S_ACTIVE: begin
        if (!STALL) begin
          if (wait_q != '0) begin
            wait_d = wait_q - WAIT_W'(1);
          end else if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + IDX_W'(1);
            phase_d = phase_q << 1;
            wait_d  = PHASE_WAIT;
          end else begin
            cycle_end = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (RUN && !step_q) begin
              phase_d = FIRST_PHASE;
              idx_d   = '0;
              wait_d  = PHASE_WAIT;
            end else begin
              state_d = S_IDLE;
              phase_d = '0;
              idx_d   = '0;
              wait_d  = '0;
              step_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign PHASE     = phase_q;
  assign PHASE_IDX = idx_q;
  assign CYCLE_END = cycle_end;
  assign BUSY      = (state_q == S_ACTIVE);
  assign CYCLE_CNT = cnt_q;

endmodule
